vga_frame_status: RTL and testbench
===================================

# vga_frame_status

Avalon-MM read-side status peripheral for the VGA sprite display. It watches the sync and blanking outputs of the VGA display peripheral's timing generator and returns frame timing to software: a 16-bit frame counter, a vblank flag, and a programmable game-tick event with interrupt and missed-tick accounting. Software uses it to pace snake movement and to update sprite registers only during vblank. It sits on the same lightweight HPS-to-FPGA bus as the display peripheral, at its own base address.

## Interface
- FRAME_W, 16: frame counter width; fixed at 16 by the register map (two byte registers).
- clk  in  1  system clock, 50 MHz, same clock as the VGA timing generator.
- reset  in  1  synchronous, active-high.
- chipselect  in  1  Avalon slave select.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- address  in  3  register index.
- writedata  in  8  write data.
- readdata  out  8  registered read data.
- irq  out  1  level interrupt; high while tick pending and enabled.
- vga_vs  in  1  VGA_VS from the timing generator; active-low, same clock domain, no synchronizer needed.
- vga_blank_n  in  1  VGA_BLANK_n from the timing generator.

## Operation
- Edge detect: vs_q register, reset 1. frame_start = vs_q & !vga_vs, a 1-cycle pulse on the falling edge of vga_vs.
- frame_cnt (16b, reset 0) increments on frame_start. Wraps 0xFFFF -> 0x0000.
- Tick divider:
  - tick_div (8b, reset 0) sets the period to tick_div+1 frames.
  - tick_cnt (8b, reset 0) is updated on frame_start: if tick_cnt == tick_div, then tick = 1 and tick_cnt <= 0; otherwise tick_cnt++.
  - Any write to tick_div also clears tick_cnt.
- Pending/missed:
  - On tick with pending = 0, set pending.
  - On tick with pending = 1, missed (8b, reset 0) increments, saturating at 255.
- irq = pending & irq_en. irq is a combinational AND of registers.
- Register map, read and write:
  - 0 R: frame_cnt[7:0]. Each read also snapshots frame_cnt[15:8] into hi_latch.
  - 1 R: hi_latch (reset 0).
  - 2 R: {5'b0, missed != 0, !vga_blank_n, pending}.
  - 2 W: bit0 = 1 clears pending; bit1 = 1 clears missed.
  - 3 R: missed.
  - 4 R/W: bit0 irq_en (reset 0); other bits read 0.
  - 5 R/W: tick_div.
  - 6, 7: read 0x00; writes ignored.
- Simultaneous events:
  - Pending clear in the same cycle as a tick: pending stays 1; missed unchanged.
  - Missed clear in the same cycle as a missed increment: missed <= 1.
  - Read of reg 0 in the same cycle as frame_start: readdata and hi_latch both take the pre-increment value, so the 16-bit pair is coherent.
  - Accesses with chipselect low are ignored. read and write asserted together: the write is performed and readdata is updated as for a read.

## Timing
- Read latency is 1 cycle. readdata is registered on the cycle after read & chipselect. It holds its last value otherwise; reset value 0x00.
- Writes take effect on the clock edge where write & chipselect is sampled.
- vga_vs falling edge sampled at edge N produces a frame_start pulse in cycle N, as seen at edge N+1:
  - frame_cnt, tick_cnt and pending update at edge N+1.
  - irq is high from edge N+1 when irq_en = 1.
- Reset values: readdata 0, irq 0, and all internal registers 0 except vs_q = 1.
- Reset in mid-frame: counters restart from 0. No spurious frame_start occurs, because vs_q = 1.

## Structure
- Package vga_frame_pkg:
  - localparams for register addresses REG_FRAME_LO .. REG_TICK_DIV.
  - status bit indices ST_PENDING, ST_VBLANK, ST_MISSED.
  - control bit index CTL_IRQ_EN.
- Sub-module frame_tick_div: inputs frame_start, tick_div, div_load; output tick. Holds tick_cnt.
- Top level holds edge detect, frame_cnt, pending/missed, register file and read mux.

## Test plan
- Reset, then drive 3 vga_vs low pulses -> reading reg 0 returns 0x03; reading reg 1 returns 0x00; irq stays 0.
- Preload by driving 0x00FF frames; read reg 0 (0xFF), drive 1 frame, read reg 1 -> 0x00 (snapshot); read reg 0 then reg 1 -> 0x00, 0x01.
- tick_div = 2, irq_en = 1, drive 3 frames -> irq rises on edge after 3rd frame_start; reg 2 = 0x01; write 0x01 to reg 2 -> irq 0.
- tick_div = 0, irq_en = 1, drive 300 frames without clearing -> reg 3 = 0xFF (saturated); reg 2 bit2 = 1; write 0x02 to reg 2 -> reg 3 = 0x00.
- Write 0x01 to reg 2 on the same cycle as a tick with pending = 1 -> pending stays 1; missed unchanged.
- Hold vga_blank_n = 0 and read reg 2 -> bit1 = 1. Read reg 6 -> 0x00. Assert reset mid-frame -> readdata 0, irq 0, reg 0 reads 0x00.

Source files
------------

// File: rtl/vga_frame_pkg.sv
// Shared constants for the VGA frame status peripheral.
// Contents: register addresses, status/control bit positions, and a
// saturating 8-bit increment helper.
package vga_frame_pkg;

    localparam int unsigned FRAME_W = 16;

    // Register map (3-bit Avalon word address)
    localparam logic [2:0] REG_FRAME_LO = 3'd0;
    localparam logic [2:0] REG_FRAME_HI = 3'd1;
    localparam logic [2:0] REG_STATUS   = 3'd2;
    localparam logic [2:0] REG_MISSED   = 3'd3;
    localparam logic [2:0] REG_CTRL     = 3'd4;
    localparam logic [2:0] REG_TICK_DIV = 3'd5;

    // Status register bits (REG_STATUS)
    localparam int unsigned ST_PENDING = 0;
    localparam int unsigned ST_VBLANK  = 1;
    localparam int unsigned ST_MISSED  = 2;

    // Control register bits (REG_CTRL)
    localparam int unsigned CTL_IRQ_EN = 0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_tick_div.sv
// Game-tick divider: emits a one-cycle tick on every (tick_div+1)-th frame start.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   frame_start_i    one-cycle pulse per frame
//   tick_div_i       period minus one, in frames
//   div_load_i       divider reprogrammed this cycle; restarts the count
//   tick_o           combinational tick pulse, aligned with frame_start_i
module frame_tick_div
    import vga_frame_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_start_i,
    input  logic [7:0] tick_div_i,
    input  logic       div_load_i,
    output logic       tick_o
);

    logic [7:0] tick_cnt_q, tick_cnt_d;
    logic       wrap;

    assign wrap   = (tick_cnt_q == tick_div_i);
    assign tick_o = frame_start_i & wrap;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        // A divider write restarts the period even if a frame starts in the same cycle.
        if (div_load_i) begin
            tick_cnt_d = 8'd0;
        end else if (frame_start_i) begin
            tick_cnt_d = wrap ? 8'd0 : tick_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tick_cnt_q <= 8'd0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/vga_frame_status.sv
// Avalon-MM status peripheral reporting VGA frame timing to software.
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   chipselect_i, read_i, write_i   Avalon slave strobes
//   address_i[2:0], writedata_i[7:0] register index / write data
//   readdata_o[7:0]                 registered read data, 1-cycle latency
//   irq_o                           level interrupt: pending & irq_en
//   vga_vs_i                        active-low vsync, same clock domain
//   vga_blank_n_i                   active-low blanking from the timing generator
module vga_frame_status
    import vga_frame_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       chipselect_i,
    input  logic       read_i,
    input  logic       write_i,
    input  logic [2:0] address_i,
    input  logic [7:0] writedata_i,
    output logic [7:0] readdata_o,
    output logic       irq_o,
    input  logic       vga_vs_i,
    input  logic       vga_blank_n_i
);

    logic               vs_q;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]         hi_latch_q, hi_latch_d;
    logic [7:0]         tick_div_q, tick_div_d;
    logic               irq_en_q, irq_en_d;
    logic               pending_q, pending_d;
    logic [7:0]         missed_q, missed_d;
    logic [7:0]         readdata_q, readdata_d;

    logic rd_en, wr_en;
    logic div_load, clr_pending, clr_missed;
    logic tick, missed_inc;

    assign frame_start = vs_q & ~vga_vs_i;

    assign rd_en       = chipselect_i & read_i;
    assign wr_en       = chipselect_i & write_i;
    assign div_load    = wr_en & (address_i == REG_TICK_DIV);
    assign clr_pending = wr_en & (address_i == REG_STATUS) & writedata_i[0];
    assign clr_missed  = wr_en & (address_i == REG_STATUS) & writedata_i[1];

    frame_tick_div u_tick_div (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .frame_start_i(frame_start),
        .tick_div_i   (tick_div_q),
        .div_load_i   (div_load),
        .tick_o       (tick)
    );

    // A tick that coincides with a pending clear just re-arms pending; it is not a miss.
    assign missed_inc = tick & pending_q & ~clr_pending;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        pending_d = pending_q;
        if (tick) begin
            pending_d = 1'b1;
        end else if (clr_pending) begin
            pending_d = 1'b0;
        end

        missed_d = missed_q;
        if (clr_missed) begin
            missed_d = missed_inc ? 8'd1 : 8'd0;
        end else if (missed_inc) begin
            missed_d = sat_inc8(missed_q);
        end

        irq_en_d   = irq_en_q;
        tick_div_d = tick_div_q;
        if (wr_en && address_i == REG_CTRL) begin
            irq_en_d = writedata_i[CTL_IRQ_EN];
        end
        if (div_load) begin
            tick_div_d = writedata_i;
        end
    end

    // Read mux samples pre-update register values, so a low-byte read in a
    // frame_start cycle captures a coherent 16-bit pair.
    always_comb begin
        readdata_d = readdata_q;
        hi_latch_d = hi_latch_q;
        if (rd_en) begin
            case (address_i)
                REG_FRAME_LO: begin
                    readdata_d = frame_cnt_q[7:0];
                    hi_latch_d = frame_cnt_q[15:8];
                end
                REG_FRAME_HI: readdata_d = hi_latch_q;
                REG_STATUS: begin
                    readdata_d             = 8'h00;
                    readdata_d[ST_PENDING] = pending_q;
                    readdata_d[ST_VBLANK]  = ~vga_blank_n_i;
                    readdata_d[ST_MISSED]  = (missed_q != 8'd0);
                end
                REG_MISSED:   readdata_d = missed_q;
                REG_CTRL:     readdata_d = {7'b0, irq_en_q};
                REG_TICK_DIV: readdata_d = tick_div_q;
                default:      readdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vs_q        <= 1'b1;
            frame_cnt_q <= '0;
            hi_latch_q  <= 8'd0;
            tick_div_q  <= 8'd0;
            irq_en_q    <= 1'b0;
            pending_q   <= 1'b0;
            missed_q    <= 8'd0;
            readdata_q  <= 8'd0;
        end else begin
            vs_q        <= vga_vs_i;
            frame_cnt_q <= frame_cnt_d;
            hi_latch_q  <= hi_latch_d;
            tick_div_q  <= tick_div_d;
            irq_en_q    <= irq_en_d;
            pending_q   <= pending_d;
            missed_q    <= missed_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata_o = readdata_q;
    assign irq_o      = pending_q & irq_en_q;

endmodule

// File: tb/tb_vga_frame_status.sv
// Scoreboard bench: the driver predicts each read result from a frame-level
// reference model and queues it; a monitor pops and compares one cycle later.
module tb_vga_frame_status;

    logic       clk = 1'b0;
    logic       reset;
    logic       chipselect, read, write;
    logic [2:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       irq;
    logic       vga_vs, vga_blank_n;

    always #5 clk = ~clk;

    vga_frame_status dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .chipselect_i (chipselect),
        .read_i       (read),
        .write_i      (write),
        .address_i    (address),
        .writedata_i  (writedata),
        .readdata_o   (readdata),
        .irq_o        (irq),
        .vga_vs_i     (vga_vs),
        .vga_blank_n_i(vga_blank_n)
    );

    int checks = 0;
    int errors = 0;

    // Queue entries: {address, expected data}
    logic [10:0] exp_q[$];
    logic        rvalid;

    // Reference model state
    int   m_frames;   // total frames since reset, mod 65536
    int   m_hi;
    int   m_phase;    // frames since last divider load
    int   m_div;
    int   m_missed;
    bit   m_pending;
    bit   m_irq_en;
    bit   m_vs_prev;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rvalid <= !reset && chipselect && read;

    always @(negedge clk) begin
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: got %02h expected no read", readdata);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                chk($sformatf("read_reg%0d", e[10:8]), readdata, e[7:0]);
            end
        end
    end

    task automatic model_reset();
        m_frames  = 0;
        m_hi      = 0;
        m_phase   = 0;
        m_div     = 0;
        m_missed  = 0;
        m_pending = 0;
        m_irq_en  = 0;
        m_vs_prev = 1;
    endtask

    // One bus cycle, entered and left at a falling clock edge.
    task automatic step(input bit cs, input bit rd, input bit wr, input bit [2:0] a,
                        input bit [7:0] wd, input bit vs, input bit blank_n);
        bit         fs, tick, clr_p, clr_m, inc;
        logic [7:0] e;
        chipselect  = cs;
        read        = rd;
        write       = wr;
        address     = a;
        writedata   = wd;
        vga_vs      = vs;
        vga_blank_n = blank_n;

        fs = m_vs_prev && !vs;
        m_vs_prev = vs;

        if (cs && rd) begin
            case (a)
                3'd0: e = 8'(m_frames % 256);
                3'd1: e = 8'(m_hi);
                3'd2: e = {5'b0, m_missed != 0, !blank_n, m_pending};
                3'd3: e = 8'(m_missed);
                3'd4: e = {7'b0, m_irq_en};
                3'd5: e = 8'(m_div);
                default: e = 8'h00;
            endcase
            exp_q.push_back({a, e});
            if (a == 3'd0) m_hi = m_frames / 256;
        end

        tick  = fs && (((m_phase + 1) % (m_div + 1)) == 0);
        clr_p = cs && wr && a == 3'd2 && wd[0];
        clr_m = cs && wr && a == 3'd2 && wd[1];
        inc   = tick && m_pending && !clr_p;

        if (clr_m)    m_missed = inc ? 1 : 0;
        else if (inc) m_missed = (m_missed < 255) ? m_missed + 1 : 255;
        if (tick)       m_pending = 1;
        else if (clr_p) m_pending = 0;

        if (cs && wr && a == 3'd5) m_phase = 0;
        else if (fs)               m_phase++;
        if (fs) m_frames = (m_frames + 1) % 65536;

        if (cs && wr && a == 3'd4) m_irq_en = wd[0];
        if (cs && wr && a == 3'd5) m_div = wd;

        @(posedge clk);
        @(negedge clk);
        chk("irq", {7'b0, irq}, {7'b0, m_pending & m_irq_en});
    endtask

    task automatic idle(input bit vs);
        step(0, 0, 0, 3'd0, 8'h00, vs, 1);
    endtask

    task automatic frame();
        idle(0);
        idle(1);
    endtask

    task automatic rd_reg(input bit [2:0] a);
        step(1, 1, 0, a, 8'h00, 1, 1);
    endtask

    task automatic wr_reg(input bit [2:0] a, input bit [7:0] d);
        step(1, 0, 1, a, d, 1, 1);
    endtask

    task automatic do_reset();
        reset       = 1;
        chipselect  = 0;
        read        = 0;
        write       = 0;
        address     = 3'd0;
        writedata   = 8'h00;
        vga_vs      = 1;
        vga_blank_n = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
        chk("reset_readdata", readdata, 8'h00);
        chk("reset_irq", {7'b0, irq}, 8'h00);
    endtask

    initial begin
        exp_q.delete();
        do_reset();

        // Basic frame counting
        repeat (3) frame();
        rd_reg(3'd0);
        rd_reg(3'd1);
        chk("irq_idle", {7'b0, irq}, 8'h00);

        // High-byte snapshot coherence across 0x00FF -> 0x0100
        repeat (252) frame();
        rd_reg(3'd0);
        frame();
        rd_reg(3'd1);
        rd_reg(3'd0);
        rd_reg(3'd1);

        // Tick period 3 with interrupt
        do_reset();
        wr_reg(3'd5, 8'd2);
        wr_reg(3'd4, 8'h01);
        frame();
        frame();
        chk("irq_before_tick", {7'b0, irq}, 8'h00);
        idle(0);
        chk("irq_on_tick", {7'b0, irq}, 8'h01);
        idle(1);
        rd_reg(3'd2);
        wr_reg(3'd2, 8'h01);
        chk("irq_cleared", {7'b0, irq}, 8'h00);

        // Missed saturation
        wr_reg(3'd5, 8'd0);
        repeat (300) frame();
        rd_reg(3'd3);
        rd_reg(3'd2);
        wr_reg(3'd2, 8'h02);
        rd_reg(3'd3);

        // Pending clear colliding with a tick
        step(1, 0, 1, 3'd2, 8'h01, 0, 1);
        chk("irq_clear_vs_tick", {7'b0, irq}, 8'h01);
        idle(1);
        rd_reg(3'd2);
        rd_reg(3'd3);

        // Low-byte read colliding with frame_start
        step(1, 1, 0, 3'd0, 8'h00, 0, 1);
        idle(1);
        rd_reg(3'd1);

        // Vblank flag, unmapped register, write ignored at 6
        step(1, 1, 0, 3'd2, 8'h00, 1, 0);
        wr_reg(3'd6, 8'hA5);
        rd_reg(3'd6);
        rd_reg(3'd7);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit [2:0] a;
            bit       cs, rd, wr, vs, bl;
            bit [7:0] wd;
            a  = 3'($urandom_range(0, 7));
            cs = ($urandom_range(0, 9) != 0);
            rd = $urandom_range(0, 1) == 1;
            wr = $urandom_range(0, 5) == 0;
            wd = 8'($urandom);
            if (a == 3'd5) wd = 8'($urandom_range(0, 3));
            vs = ($urandom_range(0, 3) != 0) ? ~m_vs_prev : m_vs_prev;
            bl = $urandom_range(0, 1) == 1;
            step(cs, rd, wr, a, wd, vs, bl);
        end

        // Reset in mid-frame
        step(1, 1, 0, 3'd0, 8'h00, 1, 1);
        do_reset();
        rd_reg(3'd0);
        rd_reg(3'd1);

        idle(1);
        idle(1);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL read_missing: got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
